// File: rtl/branch_predictor_btb.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor_btb
//  Purpose  : Dynamic branch predictor: direct-mapped branch target buffer
//             plus a pattern history table of saturating counters, indexed
//             bimodally (MODE=0) or by gshare (MODE=1, PC xor global history).
//             IF looks up combinationally; EX trains on the clock edge.
//  Ports    : clock, reset (async, active-low)
//             lookup_pc                          -> pred_hit/pred_taken/pred_target
//             upd_valid/upd_pc/upd_uncond/upd_taken/upd_target/upd_mispred
//             flush_all                          -> invalidate every BTB entry
//             stat_lookups / stat_mispred        -> saturating event counters
//  Revision : 1.0  initial release
// ============================================================================
module branch_predictor_btb #(
  parameter int ENTRIES      = 16,
  parameter int TAG_BITS     = 8,
  parameter int COUNTER_BITS = 2,
  parameter int GHR_BITS     = 4,
  parameter int MODE         = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] lookup_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_uncond,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispred,
  input  logic        flush_all,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_mispred
);

  localparam int IDX = $clog2(ENTRIES);
  localparam logic [COUNTER_BITS-1:0] CTR_MAX  = {COUNTER_BITS{1'b1}};
  localparam logic [COUNTER_BITS-1:0] CTR_INIT = COUNTER_BITS'((2 ** (COUNTER_BITS - 1)) - 1);

  // Storage
  logic                    r_valid  [ENTRIES];
  logic [TAG_BITS-1:0]     r_tag    [ENTRIES];
  logic [31:0]             r_target [ENTRIES];
  logic                    r_uncond [ENTRIES];
  logic [COUNTER_BITS-1:0] r_pht    [ENTRIES];
  logic [GHR_BITS-1:0]     r_ghr;

  // Lookup side
  logic [IDX-1:0]      w_lk_idx;
  logic [IDX-1:0]      w_lk_pht_idx;
  logic [TAG_BITS-1:0] w_lk_tag;

  // Update side
  logic [IDX-1:0]          w_upd_idx;
  logic [IDX-1:0]          w_upd_pht_idx;
  logic [TAG_BITS-1:0]     w_upd_tag;
  logic                    w_upd_hit;
  logic                    w_upd_taken;
  logic [COUNTER_BITS-1:0] w_ctr_cur;
  logic [COUNTER_BITS-1:0] w_ctr_next;

  // Low PC bits, PC bits above the tag and (in bimodal mode) the history
  // register do not influence anything; fold them here so they are read.
  logic unused_sink;
  assign unused_sink = ^{upd_pc, r_ghr};

  assign w_lk_idx  = lookup_pc[IDX+1:2];
  assign w_lk_tag  = lookup_pc[IDX+2 +: TAG_BITS];
  assign w_upd_idx = upd_pc[IDX+1:2];
  assign w_upd_tag = upd_pc[IDX+2 +: TAG_BITS];

  generate
    if (MODE == 1) begin : g_gshare
      assign w_lk_pht_idx  = w_lk_idx  ^ IDX'(r_ghr);
      assign w_upd_pht_idx = w_upd_idx ^ IDX'(r_ghr);
    end else begin : g_bimodal
      assign w_lk_pht_idx  = w_lk_idx;
      assign w_upd_pht_idx = w_upd_idx;
    end
  endgenerate

  // Combinational lookup; reads pre-update state (no bypass from EX).
  assign pred_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign pred_taken  = pred_hit && (r_uncond[w_lk_idx] || r_pht[w_lk_pht_idx][COUNTER_BITS-1]);
  assign pred_target = pred_taken ? r_target[w_lk_idx] : (lookup_pc + 32'd4);

  // Jumps always count as taken.
  assign w_upd_taken = upd_uncond || upd_taken;
  assign w_upd_hit   = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_ctr_cur   = r_pht[w_upd_pht_idx];

  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (upd_uncond) begin
      w_ctr_next = CTR_MAX;
    end else if (upd_taken) begin
      if (w_ctr_cur != CTR_MAX) w_ctr_next = w_ctr_cur + 1'b1;
    end else begin
      if (w_ctr_cur != '0) w_ctr_next = w_ctr_cur - 1'b1;
    end
  end

  // BTB: flush overrides any same-cycle update.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < ENTRIES; k++) begin
        r_valid[k]  <= 1'b0;
        r_tag[k]    <= '0;
        r_target[k] <= '0;
        r_uncond[k] <= 1'b0;
      end
    end else if (flush_all) begin
      for (int k = 0; k < ENTRIES; k++) begin
        r_valid[k] <= 1'b0;
      end
    end else if (upd_valid) begin
      if (w_upd_hit) begin
        r_target[w_upd_idx] <= upd_target;
        r_uncond[w_upd_idx] <= upd_uncond;
      end else if (w_upd_taken) begin
        // Allocate only on a taken miss; not-taken misses leave the BTB alone.
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= upd_target;
        r_uncond[w_upd_idx] <= upd_uncond;
      end
    end
  end

  // PHT and global history are unaffected by flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < ENTRIES; k++) begin
        r_pht[k] <= CTR_INIT;
      end
      r_ghr <= '0;
    end else if (upd_valid) begin
      r_pht[w_upd_pht_idx] <= w_ctr_next;
      // Only conditional branches enter the history.
      if ((MODE == 1) && !upd_uncond) begin
        r_ghr <= GHR_BITS'({r_ghr, upd_taken});
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_lookups <= '0;
      stat_mispred <= '0;
    end else if (upd_valid) begin
      if (stat_lookups != 32'hFFFF_FFFF) stat_lookups <= stat_lookups + 32'd1;
      if (upd_mispred && (stat_mispred != 32'hFFFF_FFFF)) stat_mispred <= stat_mispred + 32'd1;
    end
  end

endmodule
`default_nettype wire
